axi_lite_test_status: RTL and testbench

//  AXI-lite responder that receives the program's end-of-test result as a memory-mapped write.

---
 rtl/axi_lite_test_status.sv | 194 +++++++++++++++++++
 tb/tb_axi_lite_test_status.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_test_status.sv
// rtl/axi_lite_test_status.sv - AXI-lite end-of-test status responder (TOHOST/CYCLES/SCRATCH).
// Optional watchdog enabled by defining STATUS_WATCHDOG_EN.
module axi_lite_test_status #(
    parameter int                ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = 32'h0000_1000,
    parameter int                TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_wvalid,
    output logic              s_wready,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    output logic              s_bvalid,
    input  logic              s_bready,
    output logic [1:0]        s_bresp,
    input  logic              s_arvalid,
    output logic              s_arready,
    input  logic [ADDR_W-1:0] s_araddr,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              done,
    output logic              pass,
    output logic [31:0]       code
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef STATUS_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_DATA } r_state_t;

    w_state_t    w_state, w_state_n;
    r_state_t    r_state, r_state_n;

    logic        aw_held, w_held;
    logic        aw_hit_q;
    logic [1:0]  aw_idx_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic [1:0]  bresp_q, rresp_q;
    logic [31:0] rdata_q;
    logic [31:0] tohost_q, scratch_q, cycles_q;
    logic        done_q, pass_q;

    logic        aw_fire, w_fire, ar_fire, commit;
    logic        wr_hit, wr_err, rd_hit, rd_err, wd_hit;
    logic [1:0]  wr_idx, rd_idx;
    logic [31:0] wr_data, wr_old, wr_merged, rd_val;
    logic [3:0]  wr_strb;

    // Byte-lane bits of the addresses play no part in the word-wide decode.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_awaddr[1:0], s_araddr[1:0]};

    assign s_awready = (w_state == W_IDLE) && !aw_held;
    assign s_wready  = (w_state == W_IDLE) && !w_held;
    assign s_bvalid  = (w_state == W_RESP);
    assign s_bresp   = bresp_q;
    assign s_arready = (r_state == R_IDLE);
    assign s_rvalid  = (r_state == R_DATA);
    assign s_rdata   = rdata_q;
    assign s_rresp   = rresp_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign code      = tohost_q;

    always_comb begin
        aw_fire = s_awvalid && s_awready;
        w_fire  = s_wvalid && s_wready;
        ar_fire = s_arvalid && s_arready;
        commit  = (w_state == W_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);

        // Held captures take precedence over the live bus on the commit edge.
        wr_hit  = aw_held ? aw_hit_q : (s_awaddr[ADDR_W-1:4] == BASE_ADDR[ADDR_W-1:4]);
        wr_idx  = aw_held ? aw_idx_q : s_awaddr[3:2];
        wr_data = w_held ? w_data_q : s_wdata;
        wr_strb = w_held ? w_strb_q : s_wstrb;
        wr_err  = !wr_hit || wr_idx == 2'd1 || wr_idx == 2'd3;
        wr_old  = (wr_idx == 2'd0) ? tohost_q : scratch_q;
        for (int i = 0; i < 4; i++) begin
            wr_merged[8*i +: 8] = wr_strb[i] ? wr_data[8*i +: 8] : wr_old[8*i +: 8];
        end

        rd_hit = (s_araddr[ADDR_W-1:4] == BASE_ADDR[ADDR_W-1:4]);
        rd_idx = s_araddr[3:2];
        rd_err = !rd_hit || rd_idx == 2'd3;
        case (rd_idx)
            2'd0:    rd_val = tohost_q;
            2'd1:    rd_val = cycles_q;
            2'd2:    rd_val = scratch_q;
            default: rd_val = 32'h0;
        endcase
        if (rd_err) rd_val = 32'h0;

        wd_hit = WD_EN && !done_q && (cycles_q == 32'(TIMEOUT_CYCLES));
    end

    always_comb begin
        w_state_n = w_state;
        r_state_n = r_state;
        case (w_state)
            W_IDLE: if (commit) w_state_n = W_RESP;
            W_RESP: if (s_bready) w_state_n = W_IDLE;
            default: w_state_n = W_IDLE;
        endcase
        case (r_state)
            R_IDLE: if (ar_fire) r_state_n = R_DATA;
            R_DATA: if (s_rready) r_state_n = R_IDLE;
            default: r_state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state   <= W_IDLE;
            r_state   <= R_IDLE;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_hit_q  <= 1'b0;
            aw_idx_q  <= 2'd0;
            w_data_q  <= 32'h0;
            w_strb_q  <= 4'h0;
            bresp_q   <= RESP_OKAY;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= 32'h0;
            tohost_q  <= 32'h0;
            scratch_q <= 32'h0;
            cycles_q  <= 32'h0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            w_state <= w_state_n;
            r_state <= r_state_n;

            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bresp_q <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else begin
                if (aw_fire) begin
                    aw_held  <= 1'b1;
                    aw_hit_q <= s_awaddr[ADDR_W-1:4] == BASE_ADDR[ADDR_W-1:4];
                    aw_idx_q <= s_awaddr[3:2];
                end
                if (w_fire) begin
                    w_held   <= 1'b1;
                    w_data_q <= s_wdata;
                    w_strb_q <= s_wstrb;
                end
            end

            if (wd_hit) begin
                done_q   <= 1'b1;
                pass_q   <= 1'b0;
                tohost_q <= 32'hDEAD_0001;
            end

            if (commit && !wr_err) begin
                if (wr_idx == 2'd0) begin
                    // Zero writes and post-completion writes leave the result untouched.
                    if (!done_q && wr_merged != 32'h0) begin
                        tohost_q <= wr_merged;
                        done_q   <= 1'b1;
                        pass_q   <= (wr_merged == 32'h1);
                    end
                end else begin
                    scratch_q <= wr_merged;
                end
            end

            if (!done_q && !wd_hit && cycles_q != 32'hFFFF_FFFF) begin
                cycles_q <= cycles_q + 32'h1;
            end

            if (ar_fire) begin
                rdata_q <= rd_val;
                rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_test_status.sv
// tb/tb_axi_lite_test_status.sv - self-checking scoreboard bench for axi_lite_test_status.
module tb_axi_lite_test_status;

    localparam int ADDR_W = 32;
    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_awvalid, s_awready;
    logic [ADDR_W-1:0] s_awaddr;
    logic              s_wvalid, s_wready;
    logic [31:0]       s_wdata;
    logic [3:0]        s_wstrb;
    logic              s_bvalid, s_bready;
    logic [1:0]        s_bresp;
    logic              s_arvalid, s_arready;
    logic [ADDR_W-1:0] s_araddr;
    logic              s_rvalid, s_rready;
    logic [31:0]       s_rdata;
    logic [1:0]        s_rresp;
    logic              done, pass;
    logic [31:0]       code;

    axi_lite_test_status #(
        .ADDR_W(ADDR_W), .BASE_ADDR(32'h0000_1000), .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk), .rst(rst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .done(done), .pass(pass), .code(code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    // {compare_data, resp, data}
    logic [34:0] sb_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
        s_bready = 1; s_rready = 1;
        s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic pop_resp(input string tag, input logic [1:0] resp, input logic [31:0] data);
        logic [34:0] e;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_resp"}, 32'(resp), 32'(e[33:32]));
            if (e[34]) check({tag, "_data"}, data, e[31:0]);
        end
    endtask

    task automatic wait_bvalid(input string tag);
        int n = 0;
        while (!s_bvalid && n < 20) begin tick(); n++; end
        check({tag, "_bvalid"}, 32'(s_bvalid), 32'd1);
    endtask

    task automatic axi_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] exp_resp);
        sb_q.push_back({1'b0, exp_resp, 32'h0});
        s_awvalid = 1; s_awaddr = addr; s_wvalid = 1; s_wdata = data; s_wstrb = strb; s_bready = 1;
        tick();
        s_awvalid = 0; s_wvalid = 0;
        check({tag, "_blat"}, 32'(s_bvalid), 32'd1);
        wait_bvalid(tag);
        pop_resp(tag, s_bresp, 32'h0);
        tick();
        check({tag, "_rdy_back"}, {30'd0, s_awready, s_wready}, 32'd3);
    endtask

    task automatic axi_read(input string tag, input logic [31:0] addr, input logic use_data,
                            input logic [1:0] exp_resp, input logic [31:0] exp_data,
                            output logic [31:0] data);
        int n = 0;
        sb_q.push_back({use_data, exp_resp, exp_data});
        s_arvalid = 1; s_araddr = addr; s_rready = 1;
        tick();
        s_arvalid = 0;
        check({tag, "_rlat"}, 32'(s_rvalid), 32'd1);
        while (!s_rvalid && n < 20) begin tick(); n++; end
        pop_resp(tag, s_rresp, s_rdata);
        data = s_rdata;
        tick();
        check({tag, "_rclr"}, 32'(s_rvalid), 32'd0);
    endtask

    logic [31:0] d1, d2, d3, dummy;
    int c1, c2, c3, n;

    initial begin
        do_reset();
        check("rst_ready", {29'd0, s_awready, s_wready, s_arready}, 32'd7);
        check("rst_valid", {30'd0, s_bvalid, s_rvalid}, 32'd0);
        check("rst_done_pass", {30'd0, done, pass}, 32'd0);
        check("rst_code", code, 32'h0);
        check("rst_rdata", s_rdata, 32'h0);

`ifdef STATUS_WATCHDOG_EN
        n = 0;
        while (!done && n < 200) begin tick(); n++; end
        check("wd_done_cycle", 32'(n), 32'd51);
        check("wd_pass", 32'(pass), 32'd0);
        check("wd_code", code, 32'hDEAD_0001);
        axi_read("wd_cycles", 32'h1004, 1'b1, OKAY, 32'd50, dummy);
`else
        axi_read("cyc0", 32'h1004, 1'b1, OKAY, 32'h0, dummy);

        axi_write("scr_w", 32'h1008, 32'hA5A5_A5A5, 4'b0010, OKAY);
        axi_read("scr_r", 32'h1008, 1'b1, OKAY, 32'h0000_A500, dummy);
        check("scr_done", 32'(done), 32'd0);

        c1 = cyc;
        axi_read("cyc1", 32'h1004, 1'b0, OKAY, 32'h0, d1);
        repeat (8) tick();
        c2 = cyc;
        axi_read("cyc2", 32'h1004, 1'b0, OKAY, 32'h0, d2);
        check("cyc_apart", 32'(c2 - c1), 32'd10);
        check("cyc_diff", d2 - d1, 32'd10);
        axi_write("cyc_w", 32'h1004, 32'h1234, 4'hF, SLVERR);
        c3 = cyc;
        axi_read("cyc3", 32'h1004, 1'b0, OKAY, 32'h0, d3);
        check("cyc_diff2", d3 - d2, 32'(c3 - c2));

        sb_q.push_back({1'b1, SLVERR, 32'h0});
        s_arvalid = 1; s_araddr = 32'h100C; s_rready = 0;
        tick();
        s_arvalid = 0;
        for (int i = 0; i < 5; i++) begin
            check("unm_hold", {s_rdata[29:0], s_rresp}, {30'd0, SLVERR});
            check("unm_valid", {30'd0, s_rvalid, s_arready}, 32'd2);
            tick();
        end
        s_rready = 1;
        pop_resp("unm", s_rresp, s_rdata);
        tick();
        check("unm_clr", {30'd0, s_rvalid, s_arready}, 32'd1);

        axi_write("miss_w", 32'h2000, 32'h1, 4'hF, SLVERR);
        axi_read("miss_r", 32'h2000, 1'b1, SLVERR, 32'h0, dummy);
        check("miss_done", 32'(done), 32'd0);

        axi_write("t1", 32'h1000, 32'h1, 4'hF, OKAY);
        check("t1_result", {30'd0, done, pass}, 32'd3);
        check("t1_code", code, 32'h1);
        axi_read("frz1", 32'h1004, 1'b0, OKAY, 32'h0, d1);
        repeat (3) tick();
        axi_read("frz2", 32'h1004, 1'b0, OKAY, 32'h0, d2);
        check("cyc_frozen", d2, d1);

        s_arvalid = 1; s_araddr = 32'h1008; s_rready = 0;
        tick();
        s_arvalid = 0;
        rst = 1;
        tick();
        rst = 0;
        check("midrst_valid", {30'd0, s_rvalid, s_bvalid}, 32'd0);
        check("midrst_done", {30'd0, done, pass}, 32'd0);
        s_rready = 1;

        sb_q.push_back({1'b0, OKAY, 32'h0});
        s_wvalid = 1; s_wdata = 32'h7; s_wstrb = 4'hF; s_bready = 1;
        tick();
        s_wvalid = 0;
        for (int i = 1; i <= 3; i++) begin
            check("t2_wready", {30'd0, s_wready, s_awready}, 32'd1);
            if (i == 3) begin s_awvalid = 1; s_awaddr = 32'h1000; end
            else tick();
        end
        tick();
        s_awvalid = 0;
        check("t2_bvalid", 32'(s_bvalid), 32'd1);
        pop_resp("t2", s_bresp, 32'h0);
        check("t2_result", {30'd0, done, pass}, 32'd2);
        check("t2_code", code, 32'h7);
        tick();
        axi_write("t2_late", 32'h1000, 32'h1, 4'hF, OKAY);
        check("t2_sticky", {pass, code[30:0]}, 32'h7);
        axi_read("t2_tohost", 32'h1000, 1'b1, OKAY, 32'h7, dummy);
`endif

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
